piso_shift_ctrl: RTL and testbench

Sequencing controller for a parallel-in/serial-out register built from D flip-flop cells in the trigger/register library. A requester presents a WIDTH-bit word with a Start strobe. The controller loads the word, shifts it out one bit per Cp cycle with a valid qualifier, pulses Done, and returns ready. It sits between word-level logic and any single-wire serial consumer: LED drivers, serial links, and lab display chains.

---
 rtl/piso_pkg.sv | 24 ++
 rtl/piso_shift_ctrl_if.sv | 28 ++
 rtl/piso_shift_reg.sv | 55 +++++
 rtl/piso_shift_ctrl.sv | 112 +++++++++++
 tb/tb_piso_shift_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in/serial-out sequencing controller.
//   state_t        : controller state encoding (2'b11 is unused and recovers
//                    to IDLE on the next edge)
//   DEFAULT_WIDTH  : default word length in bits
//   start_ok()     : qualifies a Start request against Abort
// -----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A request is only honoured when Abort is low in the same cycle.
    function automatic logic start_ok(input logic start, input logic abort);
        return start & ~abort;
    endfunction

endpackage

// File: rtl/piso_shift_ctrl_if.sv
// -----------------------------------------------------------------------------
// piso_shift_ctrl_if
// Word-request / serial-output bundle between a requester and piso_shift_ctrl.
//   Start, Abort, Din        : driven by the requester (master)
//   Busy, Sout, SoutValid,
//   Done                     : driven by the controller (slave)
// -----------------------------------------------------------------------------
interface piso_shift_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic             Abort;
    logic [WIDTH-1:0] Din;
    logic             Busy;
    logic             Sout;
    logic             SoutValid;
    logic             Done;

    modport master (
        output Start, Abort, Din,
        input  Busy, Sout, SoutValid, Done
    );

    modport slave (
        input  Start, Abort, Din,
        output Busy, Sout, SoutValid, Done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
// WIDTH D flip-flops with asynchronous active-low clear and synchronous
// clear / load / shift controls. Shifting moves data toward the output end
// and fills the vacated position with zero.
//   Cp         : clock
//   Rn         : asynchronous active-low clear
//   clear_i    : synchronous clear (highest priority)
//   load_i     : load din_i
//   shift_i    : shift one position toward the output end
//   din_i      : parallel word
//   out_bit_o  : bit currently at the output end
// -----------------------------------------------------------------------------
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Cp,
    input  logic             Rn,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             out_bit_o
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (clear_i) begin
            sreg_d = '0;
        end else if (load_i) begin
            sreg_d = din_i;
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end else begin
                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge Cp or negedge Rn) begin
        if (!Rn) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign out_bit_o = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule

// File: rtl/piso_shift_ctrl.sv
// -----------------------------------------------------------------------------
// piso_shift_ctrl
// Sequencing controller for a parallel-in/serial-out register. Accepts a
// WIDTH-bit word on Start, shifts it out one bit per Cp cycle with SoutValid,
// pulses Done for one cycle after the last bit, then returns to IDLE.
// A request in DONE starts the next word with no idle cycle in between.
//   Cp   : clock, rising edge
//   Rn   : asynchronous active-low reset
//   bus  : piso_shift_ctrl_if.slave (Start, Abort, Din in;
//          Busy, Sout, SoutValid, Done out)
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module piso_shift_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               Cp,
    input  logic               Rn,
    piso_shift_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_ok;
    logic             load_c;
    logic             shift_c;
    logic             clear_c;
    logic             out_bit;

    assign req_ok = start_ok(bus.Start, bus.Abort);

    // Datapath controls. Start is only looked at in IDLE/DONE, so Din
    // changes while shifting never reach the register.
    always_comb begin
        load_c  = 1'b0;
        shift_c = 1'b0;
        clear_c = 1'b0;
        case (state_q)
            ST_IDLE:  load_c = req_ok;
            ST_DONE:  load_c = req_ok;
            ST_SHIFT: begin
                clear_c = bus.Abort;
                shift_c = ~bus.Abort;
            end
            default:  clear_c = 1'b1;
        endcase
    end

    // FSM and bit counter. The counter is loaded with WIDTH-1 and SHIFT is
    // left on the edge where it reads zero, so it never wraps.
    always_ff @(posedge Cp or negedge Rn) begin
        if (!Rn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_ok) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= CNT_LAST;
                    end
                end
                ST_SHIFT: begin
                    if (bus.Abort) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (req_ok) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= CNT_LAST;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sreg (
        .Cp        (Cp),
        .Rn        (Rn),
        .clear_i   (clear_c),
        .load_i    (load_c),
        .shift_i   (shift_c),
        .din_i     (bus.Din),
        .out_bit_o (out_bit)
    );

    assign bus.Busy      = (state_q == ST_SHIFT);
    assign bus.SoutValid = (state_q == ST_SHIFT);
    assign bus.Sout      = (state_q == ST_SHIFT) & out_bit;
    assign bus.Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_ctrl
// Directed bench for piso_shift_ctrl: an MSB-first instance (a) and an
// LSB-first instance (b) sharing clock and reset.
// Observed vector per instance: {Busy, SoutValid, Sout, Done}.
// -----------------------------------------------------------------------------
module tb_piso_shift_ctrl;

    logic Cp;
    logic Rn;

    int vectors     = 0;
    int miscompares = 0;

    piso_shift_ctrl_if #(.WIDTH(8)) a_if ();
    piso_shift_ctrl_if #(.WIDTH(8)) b_if ();

    piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .Cp  (Cp),
        .Rn  (Rn),
        .bus (a_if.slave)
    );

    piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .Cp  (Cp),
        .Rn  (Rn),
        .bus (b_if.slave)
    );

    initial Cp = 1'b0;
    always #5 Cp = ~Cp;

    localparam logic [3:0] IDLE_V = 4'b0000;
    localparam logic [3:0] DONE_V = 4'b0001;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (Busy,SoutValid,Sout,Done) at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] obs(input int which);
        if (which == 0)
            return {a_if.Busy, a_if.SoutValid, a_if.Sout, a_if.Done};
        return {b_if.Busy, b_if.SoutValid, b_if.Sout, b_if.Done};
    endfunction

    task automatic req(input int which, input logic start, input logic [7:0] din);
        if (which == 0) begin
            a_if.Start = start;
            a_if.Din   = din;
        end else begin
            b_if.Start = start;
            b_if.Din   = din;
        end
    endtask

    task automatic tick();
        @(posedge Cp);
        #1;
    endtask

    // Assumes Start/Din for 'word' are already applied. First tick is the
    // accepting edge; afterwards Start := hold, Din := next_din. Optionally
    // pulses a second request (poke_din) during slot poke_k.
    task automatic expect_bits(input int which, input string tag, input logic [7:0] word,
                               input logic hold, input logic [7:0] next_din,
                               input int poke_k, input logic [7:0] poke_din);
        logic bit_e;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) req(which, hold, next_din);
            if (poke_k >= 0 && k == poke_k + 1) req(which, 1'b0, next_din);
            bit_e = (which == 0) ? word[7-k] : word[k];
            chk($sformatf("%s_bit%0d", tag, k), obs(which), {1'b1, 1'b1, bit_e, 1'b0});
            if (k == poke_k) req(which, 1'b1, poke_din);
        end
        tick();
        chk({tag, "_done"}, obs(which), DONE_V);
    endtask

    initial begin
        Rn           = 1'b0;
        a_if.Start   = 1'b0;
        a_if.Abort   = 1'b0;
        a_if.Din     = 8'h00;
        b_if.Start   = 1'b0;
        b_if.Abort   = 1'b0;
        b_if.Din     = 8'h00;

        // Reset state
        #3;
        chk("reset_a", obs(0), IDLE_V);
        chk("reset_b", obs(1), IDLE_V);
        #4 Rn = 1'b1;
        tick();
        chk("idle_after_reset", obs(0), IDLE_V);

        // Single MSB-first transfer of A5: 1,0,1,0,0,1,0,1
        req(0, 1'b1, 8'hA5);
        expect_bits(0, "a5", 8'hA5, 1'b0, 8'hA5, -1, 8'h00);
        tick();
        chk("a5_done_one_cycle", obs(0), IDLE_V);

        // LSB-first transfer of 01: 1 then seven 0s
        req(1, 1'b1, 8'h01);
        expect_bits(1, "lsb01", 8'h01, 1'b0, 8'h01, -1, 8'h00);
        tick();
        chk("lsb01_idle", obs(1), IDLE_V);

        // Back-to-back: Start held, FF then 00 with no idle cycle
        req(0, 1'b1, 8'hFF);
        expect_bits(0, "b2b_ff", 8'hFF, 1'b1, 8'h00, -1, 8'h00);
        expect_bits(0, "b2b_00", 8'h00, 1'b0, 8'h00, -1, 8'h00);
        tick();
        chk("b2b_idle", obs(0), IDLE_V);

        // Abort during the 4th bit of F0
        req(0, 1'b1, 8'hF0);
        tick();
        req(0, 1'b0, 8'hF0);
        chk("abort_bit0", obs(0), 4'b1110);
        tick();
        chk("abort_bit1", obs(0), 4'b1110);
        tick();
        chk("abort_bit2", obs(0), 4'b1110);
        tick();
        chk("abort_bit3", obs(0), 4'b1110);
        a_if.Abort = 1'b1;
        tick();
        a_if.Abort = 1'b0;
        chk("abort_cut", obs(0), IDLE_V);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("abort_nodone%0d", i), obs(0), IDLE_V);
        end
        req(0, 1'b1, 8'h96);
        expect_bits(0, "after_abort", 8'h96, 1'b0, 8'h96, -1, 8'h00);
        tick();

        // Abort alongside Start in IDLE: request ignored
        a_if.Abort = 1'b1;
        req(0, 1'b1, 8'hFF);
        tick();
        chk("abort_blocks_start", obs(0), IDLE_V);
        a_if.Abort = 1'b0;
        req(0, 1'b0, 8'h00);

        // Start pulsed mid-shift with different Din: dropped
        req(0, 1'b1, 8'hC3);
        expect_bits(0, "midstart", 8'hC3, 1'b0, 8'hC3, 3, 8'h5A);
        tick();
        chk("midstart_dropped0", obs(0), IDLE_V);
        tick();
        chk("midstart_dropped1", obs(0), IDLE_V);

        // Asynchronous reset mid-transfer
        req(0, 1'b1, 8'hA5);
        tick();
        req(0, 1'b0, 8'hA5);
        chk("rst_pre_bit0", obs(0), 4'b1110);
        tick();
        tick();
        chk("rst_pre_bit2", obs(0), 4'b1110);
        #2 Rn = 1'b0;
        #1;
        chk("rst_async", obs(0), IDLE_V);
        tick();
        chk("rst_held", obs(0), IDLE_V);
        Rn = 1'b1;
        req(0, 1'b1, 8'h3C);
        expect_bits(0, "post_rst_3c", 8'h3C, 1'b0, 8'h3C, -1, 8'h00);
        tick();
        chk("post_rst_idle", obs(0), IDLE_V);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
